// File: rtl/fetch_buffer.sv
// fetch_buffer: small FIFO of {pc, instr} pairs between instruction fetch
// and decode. Fetch advances only while a slot is free (if_ready drives the
// PC register's enable). A redirect (flush) discards everything queued.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   if_pc, if_instr      fetched PC / instruction word
//   if_valid             fetch presents a valid pair this cycle
//   if_ready             a slot is free (enable_PC); registered state only
//   id_pc, id_instr      head entry, or RESET_PC / nop bubble when empty
//   id_valid             head entry valid
//   id_ready             decode consumes the head this cycle
//   flush                drop all queued entries at this edge
//   occupancy            number of valid entries, 0..DEPTH
module fetch_buffer #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned PTR_W    = 1,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_instr,
  input  logic             if_valid,
  output logic             if_ready,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_instr,
  output logic             id_valid,
  input  logic             id_ready,
  input  logic             flush,
  output logic [PTR_W:0]   occupancy
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;

  // head == tail is ambiguous; count alone separates full from empty.
  always_comb begin
    if_ready  = (count != CNT_FULL);
    id_valid  = (count != '0);
    occupancy = count;
    push      = if_valid & if_ready & ~flush;
    pop       = id_valid & id_ready & ~flush;
    id_pc     = RESET_PC;
    id_instr  = '0;
    if (id_valid) begin
      id_pc    = pc_mem[head];
      id_instr = instr_mem[head];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_ONE;
      if (pop)  head <= head + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; contents are only visible when counted.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      pc_mem[tail]    <= if_pc;
      instr_mem[tail] <= if_instr;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        reset;
  // DUT A: default DEPTH=2
  logic [31:0] if_pc, if_instr, id_pc, id_instr;
  logic        if_valid, if_ready, id_valid, id_ready, flush;
  logic [1:0]  occupancy;
  // DUT B: DEPTH=4, used for the pointer-wrap stream
  logic [31:0] w_if_pc, w_if_instr, w_id_pc, w_id_instr;
  logic        w_if_valid, w_if_ready, w_id_valid, w_id_ready, w_flush;
  logic [2:0]  w_occupancy;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign if_instr   = instr_of(if_pc);
  assign w_if_instr = instr_of(w_if_pc);

  fetch_buffer u_dut_a (
    .clk(clk), .reset(reset),
    .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid), .if_ready(if_ready),
    .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid), .id_ready(id_ready),
    .flush(flush), .occupancy(occupancy)
  );

  fetch_buffer #(.DEPTH(4), .PTR_W(2), .RESET_PC(32'h0000_3000)) u_dut_b (
    .clk(clk), .reset(reset),
    .if_pc(w_if_pc), .if_instr(w_if_instr), .if_valid(w_if_valid), .if_ready(w_if_ready),
    .id_pc(w_id_pc), .id_instr(w_id_instr), .id_valid(w_id_valid), .id_ready(w_id_ready),
    .flush(w_flush), .occupancy(w_occupancy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic v, input logic [31:0] pc,
                         input logic [1:0] occ, input logic rdy);
    check({tag, "_valid"}, 32'(id_valid), 32'(v));
    check({tag, "_pc"}, id_pc, pc);
    check({tag, "_instr"}, id_instr, v ? instr_of(pc) : 32'h0);
    check({tag, "_occ"}, 32'(occupancy), 32'(occ));
    check({tag, "_ifrdy"}, 32'(if_ready), 32'(rdy));
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = '0; id_ready = 1'b0;
    w_flush = 1'b0; w_if_valid = 1'b0; w_if_pc = '0; w_id_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    check_a("reset", 1'b0, 32'h3000, 2'd0, 1'b1);
    check("reset_b_occ", 32'(w_occupancy), 32'd0);
    check("reset_b_valid", 32'(w_id_valid), 32'd0);

    // Reset and drain: one-cycle latency, occupancy steady at 1
    id_ready = 1'b1; if_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_pc = 32'h3000 + 32'(4 * i);
      if (i == 0) check("drain_nobypass", 32'(id_valid), 32'd0);
      step();
      check_a($sformatf("drain%0d", i), 1'b1, 32'h3000 + 32'(4 * i), 2'd1, 1'b1);
    end
    if_valid = 1'b0;
    step();
    check_a("drain_empty", 1'b0, 32'h3000, 2'd0, 1'b1);

    // Stall fill: full blocks a third fetch, head holds
    id_ready = 1'b0; if_valid = 1'b1;
    if_pc = 32'h3000; step();
    if_pc = 32'h3004; step();
    check_a("fill_full", 1'b1, 32'h3000, 2'd2, 1'b0);
    if_pc = 32'h3008; step();
    check_a("fill_hold", 1'b1, 32'h3000, 2'd2, 1'b0);
    // pop while full with fetch pending: no full-bypass push
    id_ready = 1'b1; step();
    check_a("fill_pop", 1'b1, 32'h3004, 2'd1, 1'b1);

    // Simultaneous push and pop at occupancy 1
    if_pc = 32'h3008; step();
    check_a("pushpop", 1'b1, 32'h3008, 2'd1, 1'b1);

    // Flush with pending push and pop
    id_ready = 1'b0; if_pc = 32'h300C; step();
    check_a("pre_flush", 1'b1, 32'h3008, 2'd2, 1'b0);
    flush = 1'b1; id_ready = 1'b1; if_pc = 32'h4000; step();
    flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    check_a("flush", 1'b0, 32'h3000, 2'd0, 1'b1);
    if_valid = 1'b1; if_pc = 32'h3010; step();
    if_valid = 1'b0;
    check_a("post_flush", 1'b1, 32'h3010, 2'd1, 1'b1);
    step();
    check_a("post_flush_hold", 1'b1, 32'h3010, 2'd1, 1'b1);
    id_ready = 1'b1; step();
    check_a("post_flush_pop", 1'b0, 32'h3000, 2'd0, 1'b1);

    // Reset mid-stall together with flush
    id_ready = 1'b0; if_valid = 1'b1;
    if_pc = 32'h5000; step();
    if_pc = 32'h5004; step();
    if_valid = 1'b0;
    check_a("stall2", 1'b1, 32'h5000, 2'd2, 1'b0);
    reset = 1'b1; flush = 1'b1; step();
    reset = 1'b0; flush = 1'b0;
    check_a("reset_stall", 1'b0, 32'h3000, 2'd0, 1'b1);

    // Wrap-around on DEPTH=4: 10 PCs, id_ready toggling 1,0,1,0
    begin
      int unsigned tx = 0, rx = 0, cnt = 0, cyc = 0;
      bit push_m, pop_m;
      while (rx < 10 && cyc < 100) begin
        w_id_ready = (cyc % 2 == 0);
        w_if_valid = (tx < 10);
        w_if_pc    = 32'h3000 + 32'(4 * tx);
        check("wrap_ifrdy", 32'(w_if_ready), 32'(cnt != 4));
        check("wrap_occ", 32'(w_occupancy), cnt);
        push_m = w_if_valid && (cnt != 4);
        pop_m  = (cnt != 0) && w_id_ready;
        if (pop_m) begin
          check("wrap_pc", w_id_pc, 32'h3000 + 32'(4 * rx));
          check("wrap_instr", w_id_instr, instr_of(32'h3000 + 32'(4 * rx)));
          rx++;
        end
        if (push_m) tx++;
        if (push_m && !pop_m) cnt++;
        if (pop_m && !push_m) cnt--;
        step();
        cyc++;
      end
      w_if_valid = 1'b0; w_id_ready = 1'b0;
      check("wrap_all_out", rx, 32'd10);
      check("wrap_end_occ", 32'(w_occupancy), 32'd0);
      check("wrap_end_valid", 32'(w_id_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
